// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter that shares the register file's
// single write port (WE3/AD3/WD3) between N_REQ writeback sources.
// The winning write is registered on posedge clk so the port is stable for
// the register file's negedge write. Writes to x0 are accepted but dropped.
// A saturating counter tracks committed (non-x0) writes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               1 = issue no grants this cycle
//   req_valid/addr/data packed per-requester write requests
//   req_ready           one-hot grant (combinational)
//   rf_we/rf_addr/rf_wd registered write port (WE3/AD3/WD3)
//   grant_id            requester index behind the current rf_* contents
//   wr_count            saturating count of committed writes
module regfile_wb_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rf_we,
  output logic [AW-1:0]       rf_addr,
  output logic [DW-1:0]       rf_wd,
  output logic [GW-1:0]       grant_id,
  output logic [CNT_W-1:0]    wr_count
);

  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    gnt_idx;
  logic [GW-1:0]    scan_idx;
  logic             gnt_any;
  logic [N_REQ-1:0] gnt_vec;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic             sel_nonzero;

  // (base + off) mod N_REQ, for the rotating scan and the pointer update
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base,
                                             input int unsigned   off);
    return GW'((32'(base) + off) % N_REQ);
  endfunction

  // Round-robin scan starting at rr_ptr; first valid requester wins
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_vec  = '0;
    scan_idx = '0;
    if (!stall) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        scan_idx = wrap_idx(rr_ptr, k);
        if (!gnt_any && req_valid[scan_idx]) begin
          gnt_any  = 1'b1;
          gnt_idx  = scan_idx;
        end
      end
    end
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  // Grants are suppressed while reset is asserted
  assign req_ready = rst_n ? gnt_vec : '0;

  assign sel_addr    = req_addr[gnt_idx*AW +: AW];
  assign sel_data    = req_data[gnt_idx*DW +: DW];
  assign sel_nonzero = (sel_addr != '0);

  // Registered write port, pointer and commit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wd    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      rf_we <= 1'b0;
      if (gnt_any) begin
        rf_we    <= sel_nonzero;
        rf_addr  <= sel_addr;
        rf_wd    <= sel_data;
        grant_id <= gnt_idx;
        rr_ptr   <= wrap_idx(gnt_idx, 1);
        // Counted on the accept edge so wr_count includes the write on the port
        if (sel_nonzero && (wr_count != {CNT_W{1'b1}}))
          wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

endmodule
